// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, register offsets and FSM state types
package axi_lite_pkg;

    localparam logic [2:0] RESP_OKAY   = 3'd0;
    localparam logic [2:0] RESP_SLVERR = 3'd2;
    localparam logic [2:0] RESP_DECERR = 3'd3;

    localparam logic [3:0] OFF_OPA    = 4'h0;
    localparam logic [3:0] OFF_OPB    = 4'h4;
    localparam logic [3:0] OFF_SUM    = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    typedef enum logic {W_IDLE, W_RESP} write_state_t;
    typedef enum logic {R_IDLE, R_DATA} read_state_t;

endpackage

// File: rtl/axi_lite_strb_merge.sv
// rtl/axi_lite_strb_merge.sv - byte-lane merge of an old word with new data under a strobe mask
module axi_lite_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_lite_adder_slave.sv
// rtl/axi_lite_adder_slave.sv - AXI4-Lite slave with two operand registers, their sum and a status word
module axi_lite_adder_slave
    import axi_lite_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    write_state_t              wstate, wstate_n;
    read_state_t               rstate, rstate_n;

    logic                      awready, awready_n, wready, wready_n;
    logic                      aw_held, aw_held_n, w_held, w_held_n;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_n;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_n;
    logic [STRB_W-1:0]         wstrb_q, wstrb_n;
    logic                      bvalid, bvalid_n;
    logic [RESP_WIDTH-1:0]     bresp, bresp_n;

    logic                      arready, arready_n, rvalid, rvalid_n;
    logic [DATA_WIDTH-1:0]     rdata, rdata_n;
    logic [RESP_WIDTH-1:0]     rresp, rresp_n;

    logic [DATA_WIDTH-1:0]     opa, opa_n, opb, opb_n;
    logic [7:0]                wr_count, wr_count_n;
    logic                      carry, carry_n;
    logic [DATA_WIDTH-1:0]     unused_sum_lo;
    logic [DATA_WIDTH-1:0]     merged_opa, merged_opb, sum;
    logic                      unused_strb_msb;

    assign unused_strb_msb = s_axi_wstrb[STRB_W];
    assign sum             = opa + opb;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] diff;
        diff = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (diff < ADDR_WIDTH'(16));
    endfunction

    // Word offset within the window; the two byte-address bits are ignored.
    function automatic logic [3:0] reg_offset(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] diff;
        diff = addr - BASE_ADDR;
        return {diff[3:2], 2'b00};
    endfunction

    axi_lite_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge_opa (
        .old_word (opa),
        .new_word (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged_opa)
    );

    axi_lite_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge_opb (
        .old_word (opb),
        .new_word (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged_opb)
    );

    always_comb begin
        wstate_n   = wstate;
        awready_n  = awready;
        wready_n   = wready;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        awaddr_n   = awaddr_q;
        wdata_n    = wdata_q;
        wstrb_n    = wstrb_q;
        bvalid_n   = bvalid;
        bresp_n    = bresp;
        opa_n      = opa;
        opb_n      = opb;
        wr_count_n = wr_count;
        unique case (wstate)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    wstate_n  = W_RESP;
                    bvalid_n  = 1'b1;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    if (!in_window(awaddr_q)) begin
                        bresp_n = RESP_WIDTH'(RESP_DECERR);
                    end else begin
                        unique case (reg_offset(awaddr_q))
                            OFF_OPA: begin
                                opa_n      = merged_opa;
                                wr_count_n = wr_count + 8'd1;
                                bresp_n    = RESP_WIDTH'(RESP_OKAY);
                            end
                            OFF_OPB: begin
                                opb_n      = merged_opb;
                                wr_count_n = wr_count + 8'd1;
                                bresp_n    = RESP_WIDTH'(RESP_OKAY);
                            end
                            default: bresp_n = RESP_WIDTH'(RESP_SLVERR);
                        endcase
                    end
                end else begin
                    // Each channel is captured once and its ready stays low until the response completes.
                    if (s_axi_awvalid && awready) begin
                        aw_held_n = 1'b1;
                        awaddr_n  = s_axi_awaddr;
                        awready_n = 1'b0;
                    end else if (!aw_held) begin
                        awready_n = 1'b1;
                    end
                    if (s_axi_wvalid && wready) begin
                        w_held_n = 1'b1;
                        wdata_n  = s_axi_wdata;
                        wstrb_n  = s_axi_wstrb[STRB_W-1:0];
                        wready_n = 1'b0;
                    end else if (!w_held) begin
                        wready_n = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    wstate_n  = W_IDLE;
                end
            end
            default: wstate_n = W_IDLE;
        endcase
        {carry_n, unused_sum_lo} = opa_n + opb_n;
    end

    always_comb begin
        rstate_n  = rstate;
        arready_n = arready;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        unique case (rstate)
            R_IDLE: begin
                if (s_axi_arvalid && arready) begin
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rstate_n  = R_DATA;
                    if (!in_window(s_axi_araddr)) begin
                        rdata_n = '0;
                        rresp_n = RESP_WIDTH'(RESP_DECERR);
                    end else begin
                        rresp_n = RESP_WIDTH'(RESP_OKAY);
                        unique case (reg_offset(s_axi_araddr))
                            OFF_OPA: rdata_n = opa;
                            OFF_OPB: rdata_n = opb;
                            OFF_SUM: rdata_n = sum;
                            default: rdata_n = DATA_WIDTH'({wr_count, carry});
                        endcase
                    end
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    rstate_n  = R_IDLE;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate   <= W_IDLE;
            rstate   <= R_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
            opa      <= '0;
            opb      <= '0;
            wr_count <= '0;
            carry    <= 1'b0;
        end else begin
            wstate   <= wstate_n;
            rstate   <= rstate_n;
            awready  <= awready_n;
            wready   <= wready_n;
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            awaddr_q <= awaddr_n;
            wdata_q  <= wdata_n;
            wstrb_q  <= wstrb_n;
            bvalid   <= bvalid_n;
            bresp    <= bresp_n;
            arready  <= arready_n;
            rvalid   <= rvalid_n;
            rdata    <= rdata_n;
            rresp    <= rresp_n;
            opa      <= opa_n;
            opb      <= opb_n;
            wr_count <= wr_count_n;
            carry    <= carry_n;
        end
    end

    assign s_axi_awready = awready;
    assign s_axi_wready  = wready;
    assign s_axi_bvalid  = bvalid;
    assign s_axi_bresp   = bresp;
    assign s_axi_arready = arready;
    assign s_axi_rvalid  = rvalid;
    assign s_axi_rdata   = rdata;
    assign s_axi_rresp   = rresp;

endmodule

// File: tb/tb_axi_lite_adder_slave.sv
// tb/tb_axi_lite_adder_slave.sv - directed self-checking bench for axi_lite_adder_slave
module tb_axi_lite_adder_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [4:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]  resp;
    logic [31:0] data;

    always #5 clk = ~clk;

    axi_lite_adder_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESP_WIDTH (3),
        .BASE_ADDR  (8'h00)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. AW is raised aw_delay cycles after W; bready is held low for b_stall cycles.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] d, input logic [4:0] s,
                             input int aw_delay, input int b_stall, output logic [2:0] r);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int cyc = 0;
        int lat = 0;
        logic [2:0] r0;
        awaddr  = addr;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        awvalid = (aw_delay == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            step();
            cyc++;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done && cyc >= aw_delay) awvalid = 1'b1;
            if (w_done && !aw_done) begin
                check("wready_low_after_w", {31'd0, wready}, 32'd0);
                check("no_bvalid_before_aw", {31'd0, bvalid}, 32'd0);
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("write_hs_timeout", 32'd0, 32'd1);
        while (!bvalid && lat < 20) begin
            step();
            lat++;
        end
        check("b_latency", lat, 32'd1);
        r0 = bresp;
        for (int i = 0; i < b_stall; i++) begin
            step();
            check("bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("bresp_hold", {29'd0, bresp}, {29'd0, r0});
            check("awready_hold", {31'd0, awready}, 32'd0);
            check("wready_hold", {31'd0, wready}, 32'd0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
        r = r0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_stall,
                            output logic [31:0] d, output logic [2:0] r);
        int cyc = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && cyc < 20) begin
            step();
            cyc++;
        end
        step();
        arvalid = 1'b0;
        check("rvalid_set", {31'd0, rvalid}, 32'd1);
        d = rdata;
        r = rresp;
        for (int i = 0; i < r_stall; i++) begin
            step();
            check("rvalid_hold", {31'd0, rvalid}, 32'd1);
            check("rdata_hold", rdata, d);
            check("rresp_hold", {29'd0, rresp}, {29'd0, r});
            check("arready_hold", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
        check("arready_back", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        int cyc;
        #20;
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("first_awready", {31'd0, awready}, 32'd1);
        check("first_wready", {31'd0, wready}, 32'd1);
        check("first_arready", {31'd0, arready}, 32'd1);

        axi_write(8'h00, 32'h0000_0005, 5'h0F, 0, 0, resp);
        check("wr_opa_resp", {29'd0, resp}, 32'd0);
        axi_write(8'h04, 32'h0000_0007, 5'h0F, 0, 0, resp);
        check("wr_opb_resp", {29'd0, resp}, 32'd0);
        axi_read(8'h08, 0, data, resp);
        check("sum_5_7", data, 32'h0000_000C);
        check("sum_resp", {29'd0, resp}, 32'd0);
        axi_read(8'h0C, 0, data, resp);
        check("status_2", data, 32'h0000_0004);

        axi_write(8'h00, 32'h0000_0000, 5'h0F, 0, 0, resp);
        axi_write(8'h00, 32'hAABB_CCDD, 5'h03, 3, 0, resp);
        check("w_first_resp", {29'd0, resp}, 32'd0);
        axi_read(8'h00, 0, data, resp);
        check("opa_strb_03", data, 32'h0000_CCDD);

        axi_write(8'h00, 32'hFFFF_FFFF, 5'h0F, 0, 0, resp);
        axi_write(8'h04, 32'h0000_0002, 5'h0F, 0, 0, resp);
        axi_read(8'h08, 0, data, resp);
        check("sum_wrap", data, 32'h0000_0001);
        axi_read(8'h0C, 0, data, resp);
        check("status_carry", data, 32'h0000_000D);

        axi_write(8'h08, 32'h0000_1234, 5'h0F, 0, 0, resp);
        check("wr_sum_slverr", {29'd0, resp}, 32'd2);
        axi_read(8'h08, 0, data, resp);
        check("sum_unchanged", data, 32'h0000_0001);
        axi_write(8'h20, 32'h0000_1234, 5'h0F, 0, 0, resp);
        check("wr_unmapped_decerr", {29'd0, resp}, 32'd3);
        axi_read(8'h40, 0, data, resp);
        check("rd_unmapped_data", data, 32'd0);
        check("rd_unmapped_resp", {29'd0, resp}, 32'd3);
        axi_read(8'h0C, 0, data, resp);
        check("status_no_err_count", data, 32'h0000_000D);

        axi_write(8'h04, 32'h0000_FFFF, 5'h00, 0, 0, resp);
        check("wstrb0_resp", {29'd0, resp}, 32'd0);
        axi_read(8'h04, 0, data, resp);
        check("wstrb0_opb", data, 32'h0000_0002);
        axi_read(8'h0F, 0, data, resp);
        check("status_wstrb0_count", data, 32'h0000_000F);

        axi_write(8'h00, 32'h0000_0010, 5'h1F, 0, 5, resp);
        check("stall_wr_resp", {29'd0, resp}, 32'd0);
        axi_read(8'h0C, 5, data, resp);
        check("stall_rd_status", data, 32'h0000_0010);
        axi_read(8'h00, 0, data, resp);
        check("opa_after_stall", data, 32'h0000_0010);

        awaddr  = 8'h04;
        wdata   = 32'h0000_0099;
        wstrb   = 5'h0F;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            step();
            cyc++;
        end
        check("pre_reset_bvalid", {31'd0, bvalid}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("async_awready_clear", {31'd0, awready}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("post_reset_awready", {31'd0, awready}, 32'd1);
        axi_read(8'h00, 0, data, resp);
        check("post_reset_opa", data, 32'd0);
        axi_read(8'h04, 0, data, resp);
        check("post_reset_opb", data, 32'd0);
        axi_read(8'h0C, 0, data, resp);
        check("post_reset_status", data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
